instruction_dispatch_controller: RTL and testbench

//  Parametrised instruction-decode/dispatch controller between the CPU fetch stage and N execution sub-controllers (ADD, MUL, DIV, CMP, ...).

---
 rtl/instruction_dispatch_controller.sv | 195 +++++++++++++++++++
 tb/tb_instruction_dispatch_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_dispatch_controller.sv
// Decodes one instruction per start handshake and dispatches it to the sub-controller selected
// by its opcode, reporting done/error/next PC back to the CPU poll register.
module instruction_dispatch_controller #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned OPC_W     = 5,
    parameter int unsigned FLAG_W    = 2,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned PC_W      = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 255,
    localparam int unsigned IW = FLAG_W + OPC_W + 3 * ADDR_W + PC_W + DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [IW-1:0]               instruction,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic                        fetch_stage_enable,
    output logic [PC_W-1:0]             next_pc_to_cpu,
    output logic [NUM_UNITS-1:0]        unit_start,
    input  logic [NUM_UNITS-1:0]        unit_busy,
    input  logic [NUM_UNITS-1:0]        unit_done,
    input  logic [NUM_UNITS*PC_W-1:0]   unit_next_pc,
    output logic [FLAG_W-1:0]           operation_type,
    output logic [ADDR_W-1:0]           destination_address,
    output logic [ADDR_W-1:0]           source_1_address,
    output logic [ADDR_W-1:0]           source_2_address,
    output logic [PC_W-1:0]             pc,
    output logic [DATA_W-1:0]           source_immediate_value
);

    localparam int unsigned SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned PC_LSB   = DATA_W;
    localparam int unsigned RS2_LSB  = PC_LSB + PC_W;
    localparam int unsigned RS1_LSB  = RS2_LSB + ADDR_W;
    localparam int unsigned RD_LSB   = RS1_LSB + ADDR_W;
    localparam int unsigned OPC_LSB  = RD_LSB + ADDR_W;
    localparam int unsigned FLAG_LSB = OPC_LSB + OPC_W;

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_UNITS-1:0]   ustart_q, ustart_d;
    logic                   busy_q, busy_d, done_q, done_d, err_q, err_d, fse_q, fse_d;
    logic [PC_W-1:0]        npc_q, npc_d;
    logic [FLAG_W-1:0]      flag_q, flag_d;
    logic [ADDR_W-1:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [DATA_W-1:0]      imm_q, imm_d;

    logic [OPC_W-1:0]       in_opc;
    logic [PC_W-1:0]        in_pc;
    logic                   sel_busy, sel_done, timeout;
    logic [PC_W-1:0]        sel_npc;

    assign in_opc   = instruction[OPC_LSB +: OPC_W];
    assign in_pc    = instruction[PC_LSB +: PC_W];
    assign sel_busy = unit_busy[sel_q];
    assign sel_done = unit_done[sel_q];
    assign sel_npc  = unit_next_pc[32'(sel_q) * PC_W +: PC_W];
    assign timeout  = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        ustart_d = ustart_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        fse_d    = fse_q;
        npc_d    = npc_q;
        flag_d   = flag_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        pc_d     = pc_q;
        imm_d    = imm_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    flag_d = instruction[FLAG_LSB +: FLAG_W];
                    rd_d   = instruction[RD_LSB +: ADDR_W];
                    rs1_d  = instruction[RS1_LSB +: ADDR_W];
                    rs2_d  = instruction[RS2_LSB +: ADDR_W];
                    pc_d   = in_pc;
                    imm_d  = instruction[DATA_W-1:0];
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    fse_d  = 1'b0;
                    if (32'(in_opc) >= NUM_UNITS) begin
                        // Illegal opcode: skip the instruction without touching any unit.
                        err_d   = 1'b1;
                        npc_d   = in_pc + PC_W'(1);
                        state_d = StResp;
                    end else begin
                        sel_d    = in_opc[SEL_W-1:0];
                        ustart_d = NUM_UNITS'(1) << in_opc[SEL_W-1:0];
                        cnt_d    = '0;
                        state_d  = StLaunch;
                    end
                end
            end
            StLaunch: begin
                if (sel_busy) begin
                    ustart_d = '0;
                    cnt_d    = '0;
                    state_d  = StWait;
                end else if (timeout) begin
                    ustart_d = '0;
                    err_d    = 1'b1;
                    npc_d    = pc_q + PC_W'(1);
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWait: begin
                if (sel_done && !sel_busy) begin
                    npc_d   = sel_npc;
                    state_d = StResp;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    npc_d   = pc_q + PC_W'(1);
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResp: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                fse_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            cnt_q    <= '0;
            ustart_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fse_q    <= 1'b0;
            npc_q    <= '0;
            flag_q   <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            pc_q     <= '0;
            imm_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            ustart_q <= ustart_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            fse_q    <= fse_d;
            npc_q    <= npc_d;
            flag_q   <= flag_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            pc_q     <= pc_d;
            imm_q    <= imm_d;
        end
    end

    assign busy                   = busy_q;
    assign done                   = done_q;
    assign error                  = err_q;
    assign fetch_stage_enable     = fse_q;
    assign next_pc_to_cpu         = npc_q;
    assign unit_start             = ustart_q;
    assign operation_type         = flag_q;
    assign destination_address    = rd_q;
    assign source_1_address       = rs1_q;
    assign source_2_address       = rs2_q;
    assign pc                     = pc_q;
    assign source_immediate_value = imm_q;

endmodule

// File: tb/tb_instruction_dispatch_controller.sv
// Scoreboard bench for instruction_dispatch_controller: expected completions are queued at issue
// and popped when the controller reports done.
module tb_instruction_dispatch_controller;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [58:0] instruction;
    logic        busy, done, error, fetch_stage_enable;
    logic [4:0]  next_pc_to_cpu;
    logic [3:0]  unit_start, unit_busy, unit_done;
    logic [19:0] unit_next_pc;
    logic [1:0]  operation_type;
    logic [4:0]  destination_address, source_1_address, source_2_address, pc;
    logic [31:0] source_immediate_value;

    typedef struct packed {
        logic       err;
        logic [4:0] npc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    instruction_dispatch_controller #(
        .NUM_UNITS(4), .OPC_W(5), .FLAG_W(2), .ADDR_W(5), .PC_W(5), .DATA_W(32), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .busy(busy), .done(done), .error(error), .fetch_stage_enable(fetch_stage_enable),
        .next_pc_to_cpu(next_pc_to_cpu), .unit_start(unit_start), .unit_busy(unit_busy),
        .unit_done(unit_done), .unit_next_pc(unit_next_pc), .operation_type(operation_type),
        .destination_address(destination_address), .source_1_address(source_1_address),
        .source_2_address(source_2_address), .pc(pc),
        .source_immediate_value(source_immediate_value)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] imm_of(input logic [4:0] opc, input logic [4:0] ipc,
                                           input logic [4:0] rd);
        return 32'hA5A5_0000 | {17'h0, opc, rd, ipc};
    endfunction

    function automatic logic [58:0] mk(input logic [4:0] opc, input logic [4:0] ipc,
                                       input logic [4:0] rd);
        return {2'b01, opc, rd, rd ^ 5'h0a, rd ^ 5'h15, ipc, imm_of(opc, ipc, rd)};
    endfunction

    // Issues one instruction and plays the selected unit: busy after bdel launch cycles
    // (bdel >= TMO means never), done after work wait cycles.
    task automatic run_instr(input logic [4:0] opc, input logic [4:0] ipc, input logic [4:0] rd,
                             input int bdel, input int work, input logic [4:0] upc,
                             input bit spurious, input bit hold, input logic [58:0] nxt);
        exp_t       e, got;
        logic [3:0] oh;
        int         k, nl;
        bit         legal, tmo;
        legal = (opc < 5'd4);
        tmo   = legal && (bdel >= TMO);
        k     = int'(opc[1:0]);
        oh    = legal ? (4'b0001 << opc[1:0]) : 4'b0000;
        e.err = !legal || tmo;
        e.npc = e.err ? ipc + 5'd1 : upc;
        sb.push_back(e);
        unit_next_pc = 20'($urandom);
        instruction = mk(opc, ipc, rd);
        start = 1'b1;
        step();
        start = hold;
        if (hold) instruction = nxt;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL accept: busy/done %b%b expected 10", busy, done);
        end
        vectors++;
        if (destination_address !== rd || pc !== ipc) begin
            miscompares++;
            $display("FAIL operand_bus: rd/pc %0d/%0d expected %0d/%0d",
                     destination_address, pc, rd, ipc);
        end
        nl = legal ? (tmo ? TMO : bdel) : 0;
        for (int i = 0; i < nl; i++) begin
            vectors++;
            if (unit_start !== oh) begin
                miscompares++;
                $display("FAIL unit_start_launch: cycle %0d got %b expected %b", i, unit_start, oh);
            end
            if (!tmo && i == nl - 1) unit_busy[k] = 1'b1;
            step();
        end
        vectors++;
        if (unit_start !== 4'b0000) begin
            miscompares++;
            $display("FAIL unit_start_drop: got %b expected 0000", unit_start);
        end
        if (legal && !tmo) begin
            for (int i = 0; i < work; i++) begin
                vectors++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wait_busy: cycle %0d busy/done %b%b expected 10", i, busy, done);
                end
                if (spurious && i == 0) begin
                    unit_done[0] = 1'b1;
                    unit_next_pc[4:0] = ~upc;
                end
                if (i == work - 1) begin
                    unit_busy[k] = 1'b0;
                    unit_done[k] = 1'b1;
                    unit_next_pc[k*5 +: 5] = upc;
                end
                step();
                unit_done = 4'b0000;
            end
        end
        step();
        got = sb.pop_front();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || fetch_stage_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL retire: done/busy/fse %b%b%b expected 101", done, busy, fetch_stage_enable);
        end
        vectors++;
        if (error !== got.err || next_pc_to_cpu !== got.npc) begin
            miscompares++;
            $display("FAIL result: error/next_pc %b/%0d expected %b/%0d",
                     error, next_pc_to_cpu, got.err, got.npc);
        end
        vectors++;
        if (pc !== ipc || source_immediate_value !== imm_of(opc, ipc, rd)) begin
            miscompares++;
            $display("FAIL operand_hold: pc/imm %0d/%h expected %0d/%h",
                     pc, source_immediate_value, ipc, imm_of(opc, ipc, rd));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        instruction = '0;
        unit_busy = '0;
        unit_done = '0;
        unit_next_pc = '0;
        #1;
        vectors++;
        if ({busy, done, error, fetch_stage_enable, next_pc_to_cpu, unit_start} !== 13'h0 ||
            {destination_address, pc, source_immediate_value} !== 42'h0) begin
            miscompares++;
            $display("FAIL reset_state: outputs not all zero");
        end
        step();
        step();
        rst = 1'b0;
    endtask

    // Reset asserted between edges while LAUNCH (unit_start high) or WAIT is active.
    task automatic test_reset_mid(input bit in_wait);
        instruction = mk(5'd1, 5'd8, 5'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        if (in_wait) begin
            unit_busy[1] = 1'b1;
            step();
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({unit_start, busy, done, error, fetch_stage_enable} !== 8'h0 ||
            next_pc_to_cpu !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_mid: start/busy/done/err/fse %b%b%b%b%b expected all 0",
                     unit_start, busy, done, error, fetch_stage_enable);
        end
        unit_busy = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_add();
        run_instr(5'd0, 5'd3, 5'd7, 2, 4, 5'd4, 1'b0, 1'b0, '0);
    endtask

    task automatic test_route();
        run_instr(5'd2, 5'd10, 5'd5, 1, 3, 5'd17, 1'b1, 1'b0, '0);
    endtask

    task automatic test_illegal();
        run_instr(5'd9, 5'd31, 5'd2, 0, 0, 5'd0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_timeout();
        run_instr(5'd3, 5'd12, 5'd1, 1000, 0, 5'd0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        run_instr(5'd1, 5'd6, 5'd9, 3, 2, 5'd20, 1'b0, 1'b1, mk(5'd0, 5'd22, 5'd4));
        run_instr(5'd0, 5'd22, 5'd4, 1, 1, 5'd23, 1'b0, 1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_route();
        test_illegal();
        test_timeout();
        test_reset_mid(1'b0);
        test_add();
        test_reset_mid(1'b1);
        test_route();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
